// File: rtl/envelope_generator.sv
// ADSR envelope generator: 16-bit level stepped on sample ticks, gain taken from level[15:8].
// Optional ENVELOPE_EXP_RELEASE_EN selects a level-proportional (exponential) release step.
module envelope_generator (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       gate,
    input  logic [7:0] attack_rate,
    input  logic [7:0] decay_rate,
    input  logic [7:0] release_rate,
    input  logic [7:0] sustain_level,
    output logic [7:0] envelope,
    output logic [2:0] state,
    output logic       active,
    output logic       done
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ATTACK  = 3'd1;
    localparam logic [2:0] ST_DECAY   = 3'd2;
    localparam logic [2:0] ST_SUSTAIN = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    logic [15:0] level_q, level_d;
    logic [2:0]  state_q, state_d;
    logic        gate_q;
    logic        active_q;
    logic        done_q, done_d;

    logic        rise_s, fall_s;
    logic [16:0] level17_s;
    logic [16:0] attack_step_s, decay_step_s, release_step_s;
    logic [16:0] attack_sum_s, target_s, decay_limit_s;

    assign rise_s = gate & ~gate_q;
    assign fall_s = ~gate & gate_q;

    // 17-bit arithmetic keeps every sum and comparison free of wrap-around.
    assign level17_s     = {1'b0, level_q};
    assign attack_step_s = {9'd0, attack_rate} + 17'd1;
    assign decay_step_s  = {9'd0, decay_rate} + 17'd1;
    assign attack_sum_s  = level17_s + attack_step_s;
    assign target_s      = {1'b0, sustain_level, 8'h00};
    assign decay_limit_s = target_s + decay_step_s;

`ifdef ENVELOPE_EXP_RELEASE_EN
    assign release_step_s = {5'd0, level_q[15:4]} + 17'd1;
`else
    assign release_step_s = {9'd0, release_rate} + 17'd1;
`endif

    // Next-state and next-level: illegal state, then gate edges, then tick-driven stepping.
    always_comb begin
        level_d = level_q;
        state_d = state_q;
        done_d  = 1'b0;
        if (state_q > ST_RELEASE) begin
            state_d = ST_IDLE;
            level_d = 16'h0000;
        end else if (rise_s) begin
            state_d = ST_ATTACK;
        end else if (fall_s) begin
            if ((state_q == ST_ATTACK) || (state_q == ST_DECAY) || (state_q == ST_SUSTAIN)) begin
                state_d = ST_RELEASE;
            end else begin
                state_d = state_q;
            end
        end else if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    level_d = 16'h0000;
                end
                ST_ATTACK: begin
                    if (attack_sum_s >= 17'h0FFFF) begin
                        level_d = 16'hFFFF;
                        state_d = ST_DECAY;
                    end else begin
                        level_d = attack_sum_s[15:0];
                    end
                end
                ST_DECAY: begin
                    if (level17_s <= decay_limit_s) begin
                        level_d = target_s[15:0];
                        state_d = ST_SUSTAIN;
                    end else begin
                        level_d = level_q - decay_step_s[15:0];
                    end
                end
                ST_SUSTAIN: begin
                    level_d = target_s[15:0];
                end
                ST_RELEASE: begin
                    if (level17_s <= release_step_s) begin
                        level_d = 16'h0000;
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        level_d = level_q - release_step_s[15:0];
                    end
                end
                default: begin
                    level_d = 16'h0000;
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            level_d = level_q;
            state_d = state_q;
        end
    end

    // State, level, gate history and the registered status flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level_q  <= 16'h0000;
            state_q  <= ST_IDLE;
            gate_q   <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            level_q  <= level_d;
            state_q  <= state_d;
            gate_q   <= gate;
            active_q <= (state_d != ST_IDLE);
            done_q   <= done_d;
        end
    end

    assign envelope = level_q[15:8];
    assign state    = state_q;
    assign active   = active_q;
    assign done     = done_q;

endmodule

// File: tb/tb_envelope_generator.sv
// Directed ADSR scenarios followed by randomized gate/tick/rate traffic, all checked against a rule-level model.
module tb_envelope_generator;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick = 1'b0;
    logic       gate = 1'b0;
    logic [7:0] attack_rate = 8'd0;
    logic [7:0] decay_rate = 8'd0;
    logic [7:0] release_rate = 8'd0;
    logic [7:0] sustain_level = 8'd0;
    logic [7:0] envelope;
    logic [2:0] state;
    logic       active;
    logic       done;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: phase number, level as plain integer, previous gate, done flag.
    int m_lvl = 0;
    int m_st = 0;
    int m_gp = 0;
    int m_done = 0;

    envelope_generator dut (
        .clock(clock), .reset_n(reset_n), .tick(tick), .gate(gate),
        .attack_rate(attack_rate), .decay_rate(decay_rate),
        .release_rate(release_rate), .sustain_level(sustain_level),
        .envelope(envelope), .state(state), .active(active), .done(done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_lvl = 0; m_st = 0; m_gp = 0; m_done = 0;
    endtask

    task automatic model_step();
        int step;
        int tgt;
        int g;
        g = int'(gate);
        m_done = 0;
        if (g == 1 && m_gp == 0) begin
            m_st = 1;
        end else if (g == 0 && m_gp == 1) begin
            if (m_st >= 1 && m_st <= 3) m_st = 4;
        end else if (tick) begin
            if (m_st == 1) begin
                step = int'(attack_rate) + 1;
                if (m_lvl + step >= 65535) begin m_lvl = 65535; m_st = 2; end
                else m_lvl = m_lvl + step;
            end else if (m_st == 2) begin
                step = int'(decay_rate) + 1;
                tgt = int'(sustain_level) * 256;
                if (m_lvl <= tgt + step) begin m_lvl = tgt; m_st = 3; end
                else m_lvl = m_lvl - step;
            end else if (m_st == 3) begin
                m_lvl = int'(sustain_level) * 256;
            end else if (m_st == 4) begin
`ifdef ENVELOPE_EXP_RELEASE_EN
                step = (m_lvl / 16) + 1;
`else
                step = int'(release_rate) + 1;
`endif
                if (m_lvl <= step) begin m_lvl = 0; m_st = 0; m_done = 1; end
                else m_lvl = m_lvl - step;
            end else begin
                m_lvl = 0;
            end
        end
        m_gp = g;
    endtask

    // One clock: apply inputs, advance the model, then compare all outputs after the edge.
    task automatic cyc(input logic g, input logic t);
        gate = g;
        tick = t;
        model_step();
        @(posedge clock);
        #1;
        check("envelope", 32'(envelope), 32'(m_lvl / 256));
        check("state", 32'(state), 32'(m_st));
        check("active", 32'(active), (m_st != 0) ? 32'd1 : 32'd0);
        check("done", 32'(done), 32'(m_done));
    endtask

    initial begin
        int cnt;
        logic g;
        #12;
        check("reset_env", 32'(envelope), 32'd0);
        check("reset_state", 32'(state), 32'd0);
        check("reset_active", 32'(active), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;

        // Attack at maximum rate from IDLE
        attack_rate = 8'd255;
        cyc(1'b1, 1'b0);
        check("attack_enter", 32'(state), 32'd1);
        cnt = 0;
        while (state != 3'd2 && cnt < 400) begin cyc(1'b1, 1'b1); cnt++; end
        check("attack_ticks", 32'(cnt), 32'd256);
        check("attack_env", 32'(envelope), 32'hFF);

        // Decay to sustain 0x80
        decay_rate = 8'd255;
        sustain_level = 8'h80;
        cnt = 0;
        while (state != 3'd3 && cnt < 400) begin cyc(1'b1, 1'b1); cnt++; end
        check("decay_ticks", 32'(cnt), 32'd128);
        check("decay_env", 32'(envelope), 32'h80);

        // Sustain tracks live level changes
        sustain_level = 8'h90;
        cyc(1'b1, 1'b1);
        check("sustain_track", 32'(envelope), 32'h90);
        cyc(1'b1, 1'b0);
        sustain_level = 8'h80;
        cyc(1'b1, 1'b1);

        // Linear release from 0x8000
        release_rate = 8'd255;
        cyc(1'b0, 1'b1);
        check("release_enter", 32'(state), 32'd4);
        check("release_hold", 32'(envelope), 32'h80);
        cnt = 0;
        while (state != 3'd0 && cnt < 400) begin cyc(1'b0, 1'b1); cnt++; end
        check("release_ticks", 32'(cnt), 32'd128);
        check("release_done", 32'(done), 32'd1);
        check("release_env", 32'(envelope), 32'd0);
        check("release_active", 32'(active), 32'd0);
        cyc(1'b0, 1'b1);
        check("done_pulse_end", 32'(done), 32'd0);

        // Retrigger during release at 0x40
        cyc(1'b1, 1'b0);
        cnt = 0;
        while (state != 3'd3 && cnt < 800) begin cyc(1'b1, 1'b1); cnt++; end
        cyc(1'b0, 1'b0);
        cnt = 0;
        while (envelope != 8'h40 && cnt < 400) begin cyc(1'b0, 1'b1); cnt++; end
        check("retrig_reach", 32'(envelope), 32'h40);
        cyc(1'b1, 1'b1);
        check("retrig_state", 32'(state), 32'd1);
        check("retrig_env", 32'(envelope), 32'h40);
        cyc(1'b1, 1'b1);
        check("retrig_climb", 32'(envelope), 32'h41);

        // Asynchronous reset mid-attack at 0x77
        cnt = 0;
        while (envelope != 8'h77 && cnt < 400) begin cyc(1'b1, 1'b1); cnt++; end
        check("pre_reset_env", 32'(envelope), 32'h77);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_env", 32'(envelope), 32'd0);
        check("abort_state", 32'(state), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_active", 32'(active), 32'd0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        cyc(1'b1, 1'b0);
        check("resume_attack", 32'(state), 32'd1);

        // Randomized traffic
        g = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 59) == 0) g = ~g;
            attack_rate  = 8'($urandom_range(0, 255));
            decay_rate   = 8'($urandom_range(0, 255));
            release_rate = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 99) == 0) sustain_level = 8'($urandom_range(0, 255));
            cyc(g, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
